// File: rtl/shader_warp_scheduler.sv
// Round-robin warp scheduler feeding the shader pipeline fetch stage: one (warp id, PC) issue at a time.
// Optional issue/stall counters are enabled with SHADER_SCHED_STATS_EN.
//
// state     | meaning
// W_IDLE    | slot free, can accept a launch
// W_READY   | warp waiting to be selected for issue
// W_ISSUED  | warp in the issue register or in flight in the pipeline
module shader_warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = 2,
    parameter int PC_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch_valid,
    input  logic [PC_W-1:0]      launch_pc,
    output logic                 launch_ready,
    output logic                 issue_valid,
    output logic [WID_W-1:0]     issue_wid,
    output logic [PC_W-1:0]      issue_pc,
    input  logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [WID_W-1:0]     wb_wid,
    input  logic                 wb_halt,
    input  logic                 wb_branch,
    input  logic [PC_W-1:0]      wb_target,
    output logic [NUM_WARPS-1:0] idle_mask,
    output logic                 busy,
`ifdef SHADER_SCHED_STATS_EN
    output logic [31:0]          issue_count,
    output logic [31:0]          stall_count,
`endif
    output logic                 wb_err
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_READY  = 2'd1,
        W_ISSUED = 2'd2
    } wstate_t;

    wstate_t           state_q [NUM_WARPS];
    wstate_t           state_d [NUM_WARPS];
    logic [PC_W-1:0]   pc_q    [NUM_WARPS];
    logic [PC_W-1:0]   pc_d    [NUM_WARPS];

    logic [WID_W-1:0]  last_grant_q, last_grant_d;
    logic              issue_valid_q, issue_valid_d;
    logic [WID_W-1:0]  issue_wid_q, issue_wid_d;
    logic [PC_W-1:0]   issue_pc_q, issue_pc_d;
    logic              wb_err_q, wb_err_d;

    logic [NUM_WARPS-1:0] idle_vec, ready_vec;
    logic                 launch_found, sel_found, load_en;
    logic [WID_W-1:0]     launch_idx, sel_idx;

    // Slot status, launch pick and round-robin pick all look at registered state only.
    always_comb begin
        idle_vec     = '0;
        ready_vec    = '0;
        launch_found = 1'b0;
        launch_idx   = '0;
        sel_found    = 1'b0;
        sel_idx      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idle_vec[i]  = (state_q[i] == W_IDLE);
            ready_vec[i] = (state_q[i] == W_READY);
        end
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!launch_found && idle_vec[i]) begin
                launch_found = 1'b1;
                launch_idx   = WID_W'(i);
            end
        end
        for (int k = 1; k <= NUM_WARPS; k++) begin
            if (!sel_found && ready_vec[last_grant_q + WID_W'(k)]) begin
                sel_found = 1'b1;
                sel_idx   = last_grant_q + WID_W'(k);
            end
        end
    end

    assign load_en = !issue_valid_q || issue_ready;

    // Launch, writeback and issue always touch warps in different states, so they never collide.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        last_grant_d  = last_grant_q;
        issue_valid_d = issue_valid_q;
        issue_wid_d   = issue_wid_q;
        issue_pc_d    = issue_pc_q;
        wb_err_d      = wb_err_q;

        if (launch_valid && launch_found) begin
            state_d[launch_idx] = W_READY;
            pc_d[launch_idx]    = launch_pc;
        end

        if (wb_valid) begin
            if (state_q[wb_wid] == W_ISSUED) begin
                if (wb_halt) begin
                    state_d[wb_wid] = W_IDLE;
                end else if (wb_branch) begin
                    state_d[wb_wid] = W_READY;
                    pc_d[wb_wid]    = wb_target;
                end else begin
                    state_d[wb_wid] = W_READY;
                    pc_d[wb_wid]    = pc_q[wb_wid] + PC_W'(1);
                end
            end else begin
                wb_err_d = 1'b1;
            end
        end

        if (load_en) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_wid_d      = sel_idx;
                issue_pc_d       = pc_q[sel_idx];
                state_d[sel_idx] = W_ISSUED;
                last_grant_d     = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= W_IDLE;
                pc_q[i]    <= '0;
            end
            last_grant_q  <= WID_W'(NUM_WARPS - 1);
            issue_valid_q <= 1'b0;
            issue_wid_q   <= '0;
            issue_pc_q    <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            last_grant_q  <= last_grant_d;
            issue_valid_q <= issue_valid_d;
            issue_wid_q   <= issue_wid_d;
            issue_pc_q    <= issue_pc_d;
            wb_err_q      <= wb_err_d;
        end
    end

`ifdef SHADER_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue_valid_q && issue_ready)
                issue_count <= issue_count + 32'd1;
            if (issue_valid_q && !issue_ready)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

    assign launch_ready = |idle_vec;
    assign issue_valid  = issue_valid_q;
    assign issue_wid    = issue_wid_q;
    assign issue_pc     = issue_pc_q;
    assign idle_mask    = idle_vec;
    assign busy         = ~&idle_vec;
    assign wb_err       = wb_err_q;

endmodule
